// File: rtl/px_fifo.sv
// px_fifo: Avalon-ST pixel FIFO with SOP/EOP flags, fill level, almost-full and sticky framing error
module px_fifo #(
  parameter int SYMBOLS_PER_BEAT = 3,
  parameter int BITS_PER_SYMBOL = 8,
  parameter int DEPTH = 4,
  parameter int ALMOST_FULL = DEPTH - 1,
  localparam int DATA_WIDTH = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
  localparam int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  din_data,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   din_startofpacket,
  input  logic                   din_endofpacket,
  output logic [DATA_WIDTH-1:0]  dout_data,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   dout_startofpacket,
  output logic                   dout_endofpacket,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   almost_full,
  output logic                   pkt_err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LEVEL_WIDTH-1:0] level_nxt;
  logic push, pop, in_pkt;
  always_comb begin
    push = din_valid & din_ready;
    pop = dout_valid & dout_ready;
    level_nxt = (push & !pop) ? level + 1'b1 : (pop & !push) ? level - 1'b1 : level;
  end
  assign dout_valid = level != '0;
  assign {dout_startofpacket, dout_endofpacket, dout_data} = mem[rd_ptr];
  assign almost_full = level >= LEVEL_WIDTH'(ALMOST_FULL);
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {din_startofpacket, din_endofpacket, din_data};
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      din_ready <= 1'b1;
      in_pkt <= 1'b0;
      pkt_err <= 1'b0;
    end else begin
      level <= level_nxt;
      din_ready <= level_nxt < LEVEL_WIDTH'(DEPTH);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) begin
        in_pkt <= din_startofpacket ? !din_endofpacket : din_endofpacket ? 1'b0 : in_pkt;
        if ((din_startofpacket & !din_endofpacket & in_pkt) | (!din_startofpacket & !in_pkt)) pkt_err <= 1'b1;
      end
    end
  end
endmodule
